dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
//  Load/store initiator for the synchronous data memory. Takes one load or store
//  from the CPU memory stage, drives the memory's req/ack port with word address,
//  byte enables and lane-replicated write data. Returns aligned, sign/zero-extended
//  load data. Stalls the pipeline until the access completes, faults or times out.
// PARAMETERS
//  AW       32  CPU byte-address width; dm_addr is AW-2 bits (word address)
//  TIMEOUT  16  max cycles in REQ waiting for dm_ack; 0 = never time out
// PORTS
//  clk         in   1     system clock, rising edge
//  rst_n       in   1     asynchronous active-low reset
//  cpu_rd      in   1     load request (sampled in IDLE only)
//  cpu_wr      in   1     store request (sampled in IDLE only)
//  cpu_addr    in   AW    byte address
//  cpu_wdata   in   32    store data, right-justified
//  cpu_size    in   2     00 byte, 01 half, 10 word, 11 illegal
//  cpu_signed  in   1     1 = sign-extend loads, 0 = zero-extend
//  cpu_busy    out  1     high while state is REQ; CPU holds its inputs stable
//  cpu_done    out  1     one-cycle pulse: access completed
//  cpu_err     out  1     one-cycle pulse: access rejected or timed out
//  cpu_rdata   out  32    load result, valid with cpu_done, held until next load done
//  dm_req      out  1     memory request
//  dm_we       out  1     1 = write, 0 = read
//  dm_addr     out  AW-2  word address = cpu_addr[AW-1:2]
//  dm_be       out  4     byte enables, lane k = bits [8k+7:8k]
//  dm_wdata    out  32    lane-replicated store data
//  dm_rdata    in   32    read data, valid in the cycle dm_ack is high
//  dm_ack      in   1     memory acknowledge; ignored when dm_req is low
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE. All outputs 0, including dm_req, cpu_rdata
//    and the timeout counter. dm_req drops immediately, even mid-access.
//  - FSM: IDLE, REQ, DONE, ERR. DONE and ERR each last exactly one cycle, then IDLE.
//  - IDLE, rising edge with cpu_rd^cpu_wr:
//      - legal access -> REQ; capture addr, size, signed, we and lane-formatted data.
//      - illegal -> ERR, dm_req never raised. Illegal means: size=11; half with
//        addr[0]=1; word with addr[1:0]!=0.
//  - IDLE with cpu_rd&cpu_wr both high -> ERR.
//  - REQ: dm_req=1. dm_we, dm_addr, dm_be and dm_wdata are registered and stable
//    until the ack edge.
//  - Edge where dm_ack=1 in REQ -> DONE; dm_req low in DONE.
//  - Read data is captured at the ack edge. cpu_rdata is updated in DONE.
//  - Stores leave cpu_rdata unchanged.
//  - Min latency: accept edge E0; dm_req high in cycle 1.
//    A sync memory acks in cycle 2; cpu_done pulses in cycle 3.
//  - Timeout: counter clears on REQ entry and increments each REQ cycle without ack.
//    When it reaches TIMEOUT -> ERR, dm_req low, no cpu_done.
//    If ack and timeout occur in the same cycle, ack wins.
//  - Lanes are little-endian. k = addr[1:0].
//      - byte: be = 1<<k; wdata = {4{wdata[7:0]}}.
//      - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
//      - word: be = 1111.
//  - Loads: select lane(s) by captured addr, then extend per cpu_signed. Word passes through.
//  - cpu_done and cpu_err are never high together. cpu_busy is low in IDLE/DONE/ERR.
//  - Requests present during DONE/ERR are ignored; accepted next IDLE cycle.
// TESTING
//  - Store byte 0xA5 @0x0000_0013:
//      - dm_addr=0x4, dm_be=1000, dm_wdata=0xA5A5A5A5, dm_we=1.
//      - Ack next cycle -> cpu_done pulse 3 cycles after accept.
//  - Load half signed @0x...2, dm_rdata=0x8001_1234 -> cpu_rdata=0xFFFF8001.
//    Same access unsigned -> 0x00008001.
//  - Load word @0x...6 -> cpu_err pulse next cycle, dm_req never high.
//    cpu_rd&cpu_wr both high -> cpu_err.
//  - TIMEOUT=4, dm_ack held low -> dm_req high 4 cycles, then cpu_err pulse.
//    Ack on the 4th cycle -> cpu_done instead.
//  - rst_n low while in REQ -> dm_req, cpu_busy 0 without waiting for a clock edge.
//    After release, next load completes normally.
//  - Back-to-back loads with ack delays 0..3 cycles: each result matches a memory
//    model; no duplicate or lost dm_req.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the synchronous data memory.
// Accepts one load or store from the CPU memory stage and runs it on the
// memory's req/ack port. The word address, byte enables and lane-replicated
// write data are registered when the access is accepted. Load data is
// lane-selected and sign/zero-extended. The pipeline is stalled until the
// access completes, is rejected, or times out.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   cpu_rd, cpu_wr   load / store request, sampled in IDLE only
//   cpu_addr         byte address (AW bits)
//   cpu_wdata        right-justified store data
//   cpu_size         00 byte, 01 half, 10 word, 11 illegal
//   cpu_signed       1 = sign-extend loads
//   cpu_busy         high while the request is outstanding on the memory port
//   cpu_done         one-cycle pulse: access completed
//   cpu_err          one-cycle pulse: access rejected or timed out
//   cpu_rdata        load result, held until the next load completes
//   dm_req, dm_we    memory request / write enable
//   dm_addr          word address = cpu_addr[AW-1:2]
//   dm_be, dm_wdata  byte enables and lane-replicated write data
//   dm_rdata, dm_ack memory read data and acknowledge
module dmem_lsu #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [1:0]    cpu_size,
  input  logic          cpu_signed,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [31:0]   cpu_rdata,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-3:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  input  logic          dm_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    addr_q;
  logic [1:0]    size_q;
  logic          sgn_q;

  logic          illegal;
  logic [3:0]    be_fmt;
  logic [31:0]   wd_fmt;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          timeout_hit;

  // Status outputs decode straight from the state register, so an async
  // reset drops dm_req and cpu_busy without waiting for a clock edge.
  assign dm_req   = (state == S_REQ);
  assign cpu_busy = (state == S_REQ);
  assign cpu_done = (state == S_DONE);
  assign cpu_err  = (state == S_ERR);

  // Counter holds the number of REQ cycles already spent without ack; the
  // cycle in which it equals TIMEOUT-1 is the last one allowed.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Request legality and store lane formatting from the live CPU inputs.
  always_comb begin
    illegal = 1'b0;
    be_fmt  = 4'b1111;
    wd_fmt  = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_fmt = 4'b0001 << cpu_addr[1:0];
        wd_fmt = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        illegal = cpu_addr[0];
        be_fmt  = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_fmt  = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        illegal = (cpu_addr[1:0] != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Load lane select and extension from the captured address/size/sign.
  always_comb begin
    case (addr_q)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_rd && cpu_wr) begin
            state <= S_ERR;
          end else if (cpu_rd || cpu_wr) begin
            if (illegal) begin
              state <= S_ERR;
            end else begin
              state    <= S_REQ;
              cnt      <= '0;
              addr_q   <= cpu_addr[1:0];
              size_q   <= cpu_size;
              sgn_q    <= cpu_signed;
              dm_we    <= cpu_wr;
              dm_addr  <= cpu_addr[AW-1:2];
              dm_be    <= be_fmt;
              dm_wdata <= wd_fmt;
            end
          end
        end
        S_REQ: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (dm_ack) begin
            state <= S_DONE;
            if (!dm_we) cpu_rdata <= ld_data;
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
